// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// access-size lookup and load-result extension.
package lsu_pkg;

    // Loads and stores share the same width encodings; stores reuse the load names.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } funct3_e;

    localparam funct3_e SB = LB;
    localparam funct3_e SH = LH;
    localparam funct3_e SW = LW;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_e;

    // Access size in bytes; 0 marks an illegal encoding.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3)
            LB, LBU: size_bytes = 3'd1;
            LH, LHU: size_bytes = 3'd2;
            LW:      size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            LB:      load_extend = {{24{w[7]}}, w[7:0]};
            LH:      load_extend = {{16{w[15]}}, w[15:0]};
            LBU:     load_extend = {24'd0, w[7:0]};
            LHU:     load_extend = {16'd0, w[15:0]};
            default: load_extend = w;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Works out which byte lanes of one word belong to an access (first or second
// word of a possibly spanning access) and splices the store bytes into them.
module byte_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        half,
    output logic [31:0] merged,
    output logic [3:0]  lane_mask
);

    logic [3:0] end_pos;
    logic [2:0] pos;
    logic [1:0] idx;

    assign end_pos = {2'b00, offset} + {1'b0, size};

    // The access occupies bytes offset..offset+size-1 of an 8-byte window made of
    // two consecutive words; half selects which word of the window this lane set is.
    always_comb begin
        merged    = old_word;
        lane_mask = 4'b0000;
        pos       = 3'd0;
        idx       = 2'd0;
        for (int j = 0; j < 4; j++) begin
            pos = {half, 2'(j)};
            idx = pos[1:0] - offset;
            if (({1'b0, pos} >= {2'b00, offset}) && ({1'b0, pos} < end_pos)) begin
                lane_mask[j]     = 1'b1;
                merged[j*8 +: 8] = store_data[{idx, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide async-read RAM:
// sub-word read-merge-write stores, spanning accesses split into two words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int L  = 128,
    parameter int AW = $clog2(L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_error,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_ena,
    output logic [31:0]   mem_wr_data,
    input  logic [31:0]   mem_rd_data
);

    state_e        state;
    logic          wr_ena_q;

    logic          lat_write;
    logic [2:0]    lat_funct3;
    logic [1:0]    lat_offset;
    logic [2:0]    lat_size;
    logic          lat_spans;
    logic [31:0]   lat_wdata;
    logic [63:0]   asm_q;
    logic [63:0]   asm_next;

    logic [2:0]    req_size;
    logic [AW-1:0] req_word;
    logic          req_spans;
    logic          req_illegal;
    logic          req_range_err;

    logic          half;
    logic          in_access;
    logic [31:0]   merged_word;
    logic [3:0]    lane_mask;
    logic [31:0]   aligned;
    logic [31:0]   load_result;

    assign req_size      = size_bytes(req_funct3);
    assign req_word      = req_addr[AW+1:2];
    assign req_spans     = ({2'b00, req_addr[1:0]} + {1'b0, req_size}) > 4'd4;
    assign req_illegal   = (req_size == 3'd0) || (req_write && req_funct3[2]);
    assign req_range_err = (req_addr[31:AW+2] != '0) || (req_spans && (req_word == AW'(L - 1)));

    assign half      = (state == ACC1);
    assign in_access = (state == ACC0) || (state == ACC1);

    byte_lane_merge u_merge (
        .old_word   (mem_rd_data),
        .store_data (lat_wdata),
        .offset     (lat_offset),
        .size       (lat_size),
        .half       (half),
        .merged     (merged_word),
        .lane_mask  (lane_mask)
    );

    // Gating with reset keeps a reset landing mid-store from committing the pending half.
    assign mem_wr_ena  = wr_ena_q & rst;
    assign mem_wr_data = merged_word;

    // Load bytes collect into an 8-byte window; the result is that window shifted
    // down by the byte offset.
    always_comb begin
        asm_next = asm_q;
        if (in_access && !lat_write) begin
            for (int j = 0; j < 4; j++) begin
                if (lane_mask[j]) begin
                    if (half)
                        asm_next[32 + j*8 +: 8] = mem_rd_data[j*8 +: 8];
                    else
                        asm_next[j*8 +: 8] = mem_rd_data[j*8 +: 8];
                end
            end
        end
    end

    assign aligned     = 32'(asm_next >> {lat_offset, 3'b000});
    assign load_result = load_extend(lat_funct3, aligned);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            wr_ena_q   <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        lat_write  <= req_write;
                        lat_funct3 <= req_funct3;
                        lat_offset <= req_addr[1:0];
                        lat_size   <= req_size;
                        lat_spans  <= req_spans;
                        lat_wdata  <= req_wdata;
                        asm_q      <= '0;
                        if (req_illegal || req_range_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state    <= ACC0;
                            mem_addr <= req_word;
                            wr_ena_q <= req_write;
                        end
                    end
                end
                ACC0: begin
                    asm_q <= asm_next;
                    if (lat_spans) begin
                        state    <= ACC1;
                        mem_addr <= mem_addr + AW'(1);
                    end else begin
                        state      <= RESP;
                        wr_ena_q   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= lat_write ? 32'd0 : load_result;
                    end
                end
                ACC1: begin
                    asm_q      <= asm_next;
                    state      <= RESP;
                    wr_ena_q   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= lat_write ? 32'd0 : load_result;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    wr_ena_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
